// File: rtl/sha3_padder.sv
// sha3_padder: packs an AXI-Stream message into SHA-3 rate blocks and applies
// the 0x06 ... 0x80 multi-rate padding.
module sha3_padder #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [DATA_WIDTH-1:0]   S_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
  input  logic                    S_TVALID,
  input  logic                    S_TLAST,
  input  logic [1:0]              S_TUSER,
  output logic                    S_TREADY,
  output logic [1151:0]           Blk,
  output logic                    Blk_valid,
  output logic                    Blk_last,
  output logic [1:0]              Blk_mode,
  input  logic                    Blk_ready
);
  localparam int KW = DATA_WIDTH / 8;
  localparam logic [1:0] FILL = 2'd0, PAD = 2'd1, PADBLK = 2'd2, OUT = 2'd3;
  logic [1:0] state, cur_mode;
  logic [7:0] cnt, kept, fill_cnt, rate;
  logic [10:0] tail_bit;
  logic pend, mid, accept;
  logic [1151:0] pad_blk, tail_blk;
  // mid marks that a message is in progress, so the mode is only taken from its first beat
  assign cur_mode = mid ? Blk_mode : S_TUSER;
  assign rate = cur_mode == 2'd0 ? 8'd144 : cur_mode == 2'd1 ? 8'd136 : cur_mode == 2'd2 ? 8'd104 : 8'd72;
  assign fill_cnt = cnt + kept;
  assign accept = S_TVALID && S_TREADY;
  assign S_TREADY = state == FILL;
  assign Blk_valid = state == OUT;
  assign tail_bit = {rate - 8'd1, 3'b000};
  always_comb begin
    kept = '0;
    for (int b = 0; b < KW; b++) kept = kept + 8'(S_TKEEP[b]);
  end
  always_comb begin
    pad_blk = Blk;
    for (int i = 0; i < 144; i++) begin
      if (i == int'(cnt)) pad_blk[8*i +: 8] = Blk[8*i +: 8] | 8'h06;
      else if (i > int'(cnt)) pad_blk[8*i +: 8] = 8'h00;
      if (i == int'(rate) - 1) pad_blk[8*i +: 8] = pad_blk[8*i +: 8] | 8'h80;
    end
  end
  always_comb begin
    tail_blk = '0;
    tail_blk[7:0] = 8'h06;
    tail_blk[tail_bit +: 8] = 8'h80;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= FILL;
      cnt <= '0;
      pend <= 1'b0;
      mid <= 1'b0;
      Blk <= '0;
      Blk_last <= 1'b0;
      Blk_mode <= 2'd0;
    end else begin
      case (state)
        FILL: if (accept) begin
          mid <= 1'b1;
          if (!mid) Blk_mode <= S_TUSER;
          for (int b = 0; b < KW; b++)
            if (S_TKEEP[b]) Blk[{cnt, 3'b000} + 11'(8 * b) +: 8] <= S_TDATA[8*b +: 8];
          cnt <= fill_cnt;
          if (fill_cnt == rate) begin
            state <= OUT;
            Blk_last <= 1'b0;
            pend <= S_TLAST;
          end else if (S_TLAST) state <= PAD;
        end
        PAD: begin
          Blk <= pad_blk;
          Blk_last <= 1'b1;
          state <= OUT;
        end
        PADBLK: begin
          Blk <= tail_blk;
          Blk_last <= 1'b1;
          state <= OUT;
        end
        OUT: if (Blk_ready) begin
          Blk <= '0;
          cnt <= '0;
          pend <= 1'b0;
          Blk_last <= 1'b0;
          if (Blk_last) mid <= 1'b0;
          state <= pend ? PADBLK : FILL;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha3_padder.sv
// tb_sha3_padder: table vectors, corner sequences and random messages against
// a byte-array padding model.
module tb_sha3_padder;
  localparam int DW = 16;
  localparam int KW = DW / 8;
  logic ACLK = 1'b0, ARESETN;
  logic [DW-1:0] S_TDATA;
  logic [KW-1:0] S_TKEEP;
  logic S_TVALID, S_TLAST, S_TREADY, Blk_valid, Blk_last, Blk_ready;
  logic [1:0] S_TUSER, Blk_mode;
  logic [1151:0] Blk;
  typedef struct { logic [1151:0] blk; logic last; logic [1:0] mode; } exp_t;
  typedef struct { logic [1:0] mode; int len; int nblk; int sfx; logic [7:0] sfxb; int r; logic [7:0] endb; } vec_t;
  exp_t expq[$];
  logic [7:0] msg[$];
  logic [1151:0] last_blk;
  int n_cmp = 0, n_bad = 0, n_got;
  sha3_padder #(.DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .S_TDATA(S_TDATA), .S_TKEEP(S_TKEEP),
    .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TUSER(S_TUSER), .S_TREADY(S_TREADY),
    .Blk(Blk), .Blk_valid(Blk_valid), .Blk_last(Blk_last), .Blk_mode(Blk_mode),
    .Blk_ready(Blk_ready)
  );
  always #5 ACLK = ~ACLK;
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  function automatic int rate_of(input logic [1:0] m);
    case (m)
      2'd0: return 144;
      2'd1: return 136;
      2'd2: return 104;
      default: return 72;
    endcase
  endfunction
  // pad10*1 over the whole message as a flat byte array, then cut into rate blocks
  function automatic void model(input logic [1:0] mode, input int len);
    int r, p;
    logic [7:0] pb[];
    exp_t e;
    r = rate_of(mode);
    p = (len / r + 1) * r;
    pb = new[p];
    for (int i = 0; i < p; i++) pb[i] = i < len ? msg[i] : 8'h00;
    pb[len] = pb[len] | 8'h06;
    pb[p-1] = pb[p-1] | 8'h80;
    for (int b = 0; b < p / r; b++) begin
      e.blk = '0;
      for (int j = 0; j < r; j++) e.blk[8*j +: 8] = pb[b*r + j];
      e.last = b == p / r - 1;
      e.mode = mode;
      expq.push_back(e);
    end
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic chk_blk(input string nm, input logic [1151:0] a, input logic [1151:0] e);
    int i;
    n_cmp++;
    if (a !== e) begin
      i = 0;
      while (i < 143 && a[8*i +: 8] === e[8*i +: 8]) i++;
      n_bad++;
      $display("FAIL %s: byte %0d got %02h expected %02h", nm, i, a[8*i +: 8], e[8*i +: 8]);
    end
  endtask
  task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [1:0] u);
    int g;
    logic rdy;
    g = 0;
    S_TDATA = d; S_TKEEP = k; S_TLAST = l; S_TUSER = u; S_TVALID = 1'b1;
    do begin
      @(negedge ACLK); rdy = S_TREADY;
      @(posedge ACLK); #1; g++;
    end while (!rdy && g < 2000);
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: got no S_TREADY expected acceptance");
    end
    S_TVALID = 1'b0; S_TLAST = 1'b0;
  endtask
  task automatic send_msg(input logic [1:0] mode, input bit gaps);
    int len, pos, nb;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    len = msg.size();
    pos = 0;
    do begin
      nb = len - pos > KW ? KW : len - pos;
      k = '0;
      for (int i = 0; i < KW; i++) begin
        d[8*i +: 8] = i < nb ? msg[pos + i] : 8'($urandom);
        if (i < nb) k[i] = 1'b1;
      end
      if (gaps) repeat ($urandom_range(2)) begin @(posedge ACLK); #1; end
      beat(d, k, pos + KW >= len, pos == 0 ? mode : 2'($urandom));
      pos += KW;
    end while (pos < len);
  endtask
  task automatic collect(input int n, input int ready_pct);
    int cyc;
    logic stalled;
    logic [1151:0] prev;
    exp_t e;
    n_got = 0; cyc = 0; stalled = 1'b0; prev = '0;
    while (n_got < n && cyc < 5000) begin
      @(negedge ACLK); cyc++;
      Blk_ready = $urandom_range(99) < ready_pct;
      #1;
      if (Blk_valid) begin
        chk("tready_in_out", S_TREADY, 0);
        if (stalled) chk_blk("hold_blk", Blk, prev);
        if (Blk_ready) begin
          if (expq.size() == 0) chk("extra_blk", 1, 0);
          else begin
            e = expq.pop_front();
            chk_blk("blk", Blk, e.blk);
            chk("blk_last", Blk_last, e.last);
            chk("blk_mode", Blk_mode, e.mode);
          end
          last_blk = Blk;
          n_got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = Blk;
        end
      end
    end
    if (n_got < n) chk("collect_timeout", n_got, n);
    @(posedge ACLK); #1;
    Blk_ready = 1'b0;
  endtask
  task automatic rst_chk(input string nm);
    chk({nm, "_valid"}, Blk_valid, 0);
    chk({nm, "_last"}, Blk_last, 0);
    chk({nm, "_mode"}, Blk_mode, 0);
    chk({nm, "_tready"}, S_TREADY, 1);
    chk_blk({nm, "_blk"}, Blk, '0);
  endtask
  initial begin
    vec_t tbl[10];
    exp_t e;
    int n;
    logic seen;
    logic [1:0] m;
    tbl[0] = '{2'd1, 0, 1, 0, 8'h06, 136, 8'h80};
    tbl[1] = '{2'd1, 3, 1, 3, 8'h06, 136, 8'h80};
    tbl[2] = '{2'd1, 135, 1, 135, 8'h86, 136, 8'h86};
    tbl[3] = '{2'd1, 136, 2, 0, 8'h06, 136, 8'h80};
    tbl[4] = '{2'd3, 72, 2, 0, 8'h06, 72, 8'h80};
    tbl[5] = '{2'd3, 136, 2, 64, 8'h06, 72, 8'h80};
    tbl[6] = '{2'd0, 143, 1, 143, 8'h86, 144, 8'h86};
    tbl[7] = '{2'd2, 208, 3, 0, 8'h06, 104, 8'h80};
    tbl[8] = '{2'd0, 100, 1, 100, 8'h06, 144, 8'h80};
    tbl[9] = '{2'd2, 1, 1, 1, 8'h06, 104, 8'h80};
    ARESETN = 1'b0; S_TDATA = '0; S_TKEEP = '0; S_TVALID = 1'b0; S_TLAST = 1'b0;
    S_TUSER = 2'd0; Blk_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    rst_chk("reset");
    ARESETN = 1'b1;
    chk("tready_after_rst", S_TREADY, 1);
    for (int i = 0; i < 10; i++) begin
      msg.delete();
      for (int j = 0; j < tbl[i].len; j++) msg.push_back(8'(j * 7 + 1));
      model(tbl[i].mode, tbl[i].len);
      n = expq.size();
      fork
        send_msg(tbl[i].mode, 1'b0);
        collect(n, 100);
      join
      chk("tbl_nblk", n_got, tbl[i].nblk);
      chk("tbl_sfx", last_blk[8*tbl[i].sfx +: 8], tbl[i].sfxb);
      chk("tbl_end", last_blk[8*(tbl[i].r - 1) +: 8], tbl[i].endb);
      if (tbl[i].r < 144) chk("tbl_hi_zero", (last_blk >> (8 * tbl[i].r)) != '0, 0);
    end
    msg = {8'h61, 8'h62, 8'h63};
    model(2'd1, 3);
    e = expq.pop_front();
    beat(16'h6261, 2'b11, 1'b0, 2'd1);
    beat(16'h0063, 2'b01, 1'b1, 2'd3);
    chk("lat_pad_c0", Blk_valid, 0);
    @(posedge ACLK); #1;
    chk("lat_pad_c1", Blk_valid, 1);
    repeat (10) begin
      chk("stall_valid", Blk_valid, 1);
      chk("stall_tready", S_TREADY, 0);
      chk_blk("stall_blk", Blk, e.blk);
      @(posedge ACLK); #1;
    end
    chk("abc_byte3", Blk[31:24], 8'h06);
    chk("abc_last", Blk_last, 1);
    chk("abc_mode", Blk_mode, 1);
    Blk_ready = 1'b1;
    @(posedge ACLK); #1;
    Blk_ready = 1'b0;
    chk("post_xfer_valid", Blk_valid, 0);
    chk("post_xfer_tready", S_TREADY, 1);
    msg.delete();
    for (int j = 0; j < 72; j++) msg.push_back(8'($urandom));
    send_msg(2'd3, 1'b0);
    chk("lat_full", Blk_valid, 1);
    chk("full_last", Blk_last, 0);
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    rst_chk("rst_out");
    for (int j = 0; j < 20; j++) beat(16'($urandom), 2'b11, 1'b0, 2'd2);
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    rst_chk("rst_fill");
    msg = {8'h61, 8'h62, 8'h63};
    model(2'd1, 3);
    fork
      send_msg(2'd1, 1'b0);
      collect(1, 100);
    join
    chk("abc_after_rst_cnt", n_got, 1);
    seen = 1'b0;
    Blk_ready = 1'b1;
    repeat (20) begin
      @(negedge ACLK);
      if (Blk_valid) seen = 1'b1;
    end
    @(posedge ACLK); #1;
    Blk_ready = 1'b0;
    chk("no_extra_blk", seen, 0);
    for (int t = 0; t < 30; t++) begin
      msg.delete();
      n = $urandom_range(300);
      for (int j = 0; j < n; j++) msg.push_back(8'($urandom));
      m = 2'($urandom);
      model(m, n);
      n = expq.size();
      fork
        send_msg(m, 1'b1);
        collect(n, $urandom_range(20, 100));
      join
    end
    chk("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
